// File: rtl/alu_pkg.sv
// Shared opcode encodings and control-state type for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_ADDI = 4'b1010;
  localparam logic [3:0] ALU_DIV  = 4'b1110;
  localparam logic [3:0] ALU_MUL  = 4'b1111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared WIDTH-step datapath: unsigned shift-add multiply or restoring divide.
module alu_muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             mul_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d, mul_q, mul_d;
  logic [WIDTH:0]   add_sum, shl, sub_diff;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH + 1){1'b0}});
    shl      = {hi_q, lo_q[WIDTH-1]};
    sub_diff = shl - {1'b0, opb_q};
    if (mul_q) begin
      step_hi = add_sum[WIDTH:1];
      step_lo = {add_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      // A borrow out of the trial subtract means the shifted remainder is restored.
      step_hi = sub_diff[WIDTH] ? shl[WIDTH-1:0] : sub_diff[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ~sub_diff[WIDTH]};
    end
  end

  // Outputs carry the post-step value so the caller can register the final result directly.
  assign done_o = busy_q && (cnt_q == CntLast);
  assign lo_o   = step_lo;
  assign hi_o   = step_hi;

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opb_d  = opb_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    mul_d  = mul_q;
    if (start_i) begin
      hi_d   = '0;
      lo_d   = a_i;
      opb_d  = b_i;
      mul_d  = mul_i;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      hi_d   = step_hi;
      lo_d   = step_lo;
      cnt_d  = cnt_q + 1'b1;
      busy_d = ~done_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opb_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      mul_q  <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opb_q  <= opb_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      mul_q  <= mul_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: valid/ready handshake, registered results, iterative MUL/DIV.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter bit          SLT_SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_hi,
  output logic             zero_flag,
  output logic             ovf_flag,
  output logic             div_by_zero
);

  alu_state_e       state_q, state_d;
  logic             out_valid_q, out_valid_d, zero_q, zero_d, ovf_q, ovf_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d, alu_hi_q, alu_hi_d;
  logic             accept, iter_start, iter_done, res_legal, res_ovf, slt;
  logic [WIDTH-1:0] iter_lo, iter_hi, sum, diff, res;

  assign in_ready   = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept     = in_valid && in_ready;
  assign iter_start = accept && (alu_control == ALU_MUL || (alu_control == ALU_DIV && b != '0));

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .start_i(iter_start),
    .mul_i  (alu_control == ALU_MUL),
    .a_i    (a),
    .b_i    (b),
    .done_o (iter_done),
    .lo_o   (iter_lo),
    .hi_o   (iter_hi)
  );

  always_comb begin
    sum       = a + b;
    diff      = a - b;
    slt       = SLT_SIGNED ? ($signed(a) < $signed(b)) : (a < b);
    res       = '0;
    res_legal = 1'b1;
    res_ovf   = 1'b0;
    case (alu_control)
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_ADD, ALU_ADDI: begin
        res     = sum;
        res_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        res     = diff;
        res_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT: res = {{(WIDTH - 1){1'b0}}, slt};
      ALU_NOR: res = ~(a | b);
      ALU_DIV: res = '1;  // only reached here when b == 0
      ALU_MUL: res = '0;
      default: res_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    alu_out_d   = alu_out_q;
    alu_hi_d    = alu_hi_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;
    if (state_q == DONE && out_ready) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
    if ((state_q == MUL || state_q == DIV) && iter_done) begin
      state_d     = DONE;
      out_valid_d = 1'b1;
      alu_out_d   = iter_lo;
      alu_hi_d    = iter_hi;
      zero_d      = (iter_lo == '0);
      ovf_d       = 1'b0;
      dbz_d       = 1'b0;
    end
    if (accept) begin
      if (iter_start) begin
        state_d     = (alu_control == ALU_MUL) ? MUL : DIV;
        out_valid_d = 1'b0;
      end else begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        alu_out_d   = res;
        alu_hi_d    = (alu_control == ALU_DIV) ? a : '0;
        zero_d      = res_legal && (res == '0);
        ovf_d       = res_ovf;
        dbz_d       = (alu_control == ALU_DIV);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      alu_hi_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      alu_hi_q    <= alu_hi_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_out     = alu_out_q;
  assign alu_hi      = alu_hi_q;
  assign zero_flag   = zero_q;
  assign ovf_flag    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomised self-checking bench for alu_mc against an arithmetic reference model.
module tb_alu_mc;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         z;
    logic         ovf;
    logic         dbz;
  } res_t;

  logic         clk, rst_n, in_valid, out_ready;
  logic [W-1:0] a, b;
  logic [3:0]   alu_control;
  logic         in_ready, out_valid, zero_flag, ovf_flag, div_by_zero;
  logic [W-1:0] alu_out, alu_hi;
  logic         s_in_ready, s_out_valid, s_zero_flag, s_ovf_flag, s_div_by_zero;
  logic [W-1:0] s_alu_out, s_alu_hi;

  int checks = 0;
  int errors = 0;

  alu_mc #(.WIDTH(W), .SLT_SIGNED(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .alu_control(alu_control), .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .alu_hi(alu_hi), .zero_flag(zero_flag), .ovf_flag(ovf_flag),
    .div_by_zero(div_by_zero)
  );

  alu_mc #(.WIDTH(W), .SLT_SIGNED(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b),
    .alu_control(alu_control), .out_valid(s_out_valid), .out_ready(out_ready),
    .alu_out(s_alu_out), .alu_hi(s_alu_hi), .zero_flag(s_zero_flag), .ovf_flag(s_ovf_flag),
    .div_by_zero(s_div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic [3:0] op, input bit sgn);
    res_t r;
    longint sa, sb, s;
    logic [63:0] p;
    bit legal;
    r = '0;
    legal = 1'b1;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    case (op)
      4'b0000: r.lo = ma & mb;
      4'b0001: r.lo = ma | mb;
      4'b0010, 4'b1010: begin
        r.lo = ma + mb;
        s = sa + sb;
        r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        r.lo = ma - mb;
        s = sa - sb;
        r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: r.lo = sgn ? W'(sa < sb) : W'(ma < mb);
      4'b1100: r.lo = ~(ma | mb);
      4'b1110: begin
        if (mb == 0) begin
          r.lo = '1;
          r.hi = ma;
          r.dbz = 1'b1;
        end else begin
          r.lo = ma / mb;
          r.hi = ma % mb;
        end
      end
      4'b1111: begin
        p = {32'b0, ma} * {32'b0, mb};
        r.lo = p[31:0];
        r.hi = p[63:32];
      end
      default: legal = 1'b0;
    endcase
    r.z = legal && (r.lo == 0);
    return r;
  endfunction

  task automatic check_res(input string tag, input res_t e0, input res_t e1);
    check({tag, "_out"}, alu_out, e0.lo);
    check({tag, "_hi"}, alu_hi, e0.hi);
    check({tag, "_zero"}, zero_flag, e0.z);
    check({tag, "_ovf"}, ovf_flag, e0.ovf);
    check({tag, "_dbz"}, div_by_zero, e0.dbz);
    check({tag, "_sout"}, s_alu_out, e1.lo);
  endtask

  // Issue one op from idle, wait for its result, optionally hold it under backpressure.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [3:0] top, input int hold);
    res_t e0, e1;
    int lat, exp_lat;
    bit rdy_seen;
    e0 = model(ta, tb, top, 1'b0);
    e1 = model(ta, tb, top, 1'b1);
    exp_lat = (top == 4'b1111 || (top == 4'b1110 && tb != 0)) ? W + 1 : 1;
    @(negedge clk);
    check("issue_rdy", in_ready, 1);
    a = ta;
    b = tb;
    alu_control = top;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    alu_control = 4'($urandom);
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("busy_rdy", rdy_seen, 0);
    check_res("res", e0, e1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_rdy", in_ready, 0);
      check_res("hold", e0, e1);
    end
    out_ready = 1'b1;
  endtask

  logic [W-1:0] tv_a   [7] = '{32'h0000F0F0, 32'h0000F0F0, 32'h0000F0F0, 32'h00001234,
                               32'h0000F0F0, 32'h0000F0F0, 32'h0000F0F0};
  logic [W-1:0] tv_b   [7] = '{32'h00FF00FF, 32'h00FF00FF, 32'h00FF00FF, 32'h00001234,
                               32'h00FF00FF, 32'h00FF00FF, 32'h00FF00FF};
  logic [3:0]   tv_op  [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1010};
  logic [W-1:0] tv_exp [7] = '{32'h000000F0, 32'h00FFF0FF, 32'h00FFF1EF, 32'h00000000,
                               32'h00000001, 32'hFF000F00, 32'h00FFF1EF};
  logic [3:0]   legal_ops [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100,
                                  4'b1010, 4'b1110, 4'b1111};
  logic [3:0]   bad_ops [7] = '{4'b0011, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1011, 4'b1101};

  initial begin
    bit spurious;
    logic [W-1:0] ra, rb;
    logic [3:0] rop;
    int sel;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    alu_control = '0;
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_out", alu_out, 0);
    check("rst_hi", alu_hi, 0);
    check("rst_flags", {zero_flag, ovf_flag, div_by_zero}, 0);
    check("rst_rdy", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back single-cycle stream
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("b2b_valid", out_valid, 1);
        check("b2b_rdy", in_ready, 1);
        check("b2b_lit", alu_out, tv_exp[i-1]);
        check_res("b2b", model(tv_a[i-1], tv_b[i-1], tv_op[i-1], 1'b0),
                  model(tv_a[i-1], tv_b[i-1], tv_op[i-1], 1'b1));
      end
      if (i < 7) begin
        a = tv_a[i];
        b = tv_b[i];
        alu_control = tv_op[i];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end

    run_op(32'h7FFFFFFF, 32'h1, 4'b0010, 0);
    check("add_ovf_lit", {alu_out, 31'b0, ovf_flag}, {32'h80000000, 32'h1});
    run_op(32'hFFFFFFFF, 32'h1, 4'b0111, 0);
    check("slt_u_lit", alu_out, 0);
    check("slt_s_lit", s_alu_out, 1);

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1111, 0);
    check("mul_lit", {alu_hi, alu_out}, 64'hFFFFFFFE_00000001);

    run_op(32'd100, 32'd7, 4'b1110, 0);
    check("div_lit", {alu_hi, alu_out}, {32'd2, 32'd14});
    run_op(32'd5, 32'd0, 4'b1110, 0);
    check("div0_lit", {alu_hi, alu_out}, {32'd5, 32'hFFFFFFFF});
    check("div0_flag", div_by_zero, 1);

    // Backpressure, then new op offered in the same cycle the result is taken
    run_op(32'd9, 32'd4, 4'b0110, 5);
    a = 32'd10;
    b = 32'd20;
    alu_control = 4'b0010;
    in_valid = 1'b1;
    #1;
    check("handoff_rdy", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("handoff_valid", out_valid, 1);
    check("handoff_out", alu_out, 30);

    // Asynchronous reset while a result is held
    @(negedge clk);
    a = 32'd1;
    b = 32'd1;
    alu_control = 4'b0010;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_out", alu_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Reset mid-MUL discards it
    @(negedge clk);
    a = 32'd1234;
    b = 32'd5678;
    alu_control = 4'b1111;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mulrst_valid", out_valid, 0);
    check("mulrst_rdy", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    repeat (W + 5) begin
      @(negedge clk);
      if (out_valid) spurious = 1'b1;
    end
    check("mulrst_discard", spurious, 0);
    run_op(32'd2, 32'd3, 4'b0010, 0);
    check("post_rst_add", alu_out, 5);

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 7);
      ra = $urandom;
      rb = $urandom;
      if (sel == 0) rb = '0;
      else if (sel == 1) rb = ra;
      else if (sel == 2) begin
        ra = $urandom_range(0, 255);
        rb = $urandom_range(0, 255);
      end
      if ($urandom_range(0, 9) == 0) rop = bad_ops[$urandom_range(0, 6)];
      else rop = legal_ops[$urandom_range(0, 8)];
      run_op(ra, rb, rop, $urandom_range(0, 2));
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle integer ALU for the execute stage of the pipelined 32-bit processor.
- Keeps the existing 4-bit ALU control encoding.
- Single-cycle logic and add ops have a registered result. MUL uses an iterative shift-add unit; DIV uses a restoring divider.
- Valid/ready handshakes on both sides let the hazard unit stall the pipeline while MUL/DIV run.

Parameters:
- WIDTH, 32: operand/result width, must be ≥ 4.
- SLT_SIGNED, 0: 0 means SLT compares unsigned; 1 means two's-complement compare.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  block accepts operation this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- alu_control  in  4  opcode
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- alu_out  out  WIDTH  result / product low half / quotient
- alu_hi  out  WIDTH  product high half / remainder; 0 for other ops
- zero_flag  out  1  alu_out == 0
- ovf_flag  out  1  signed overflow, ADD/ADDI/SUB only
- div_by_zero  out  1  DIV with b == 0

Behaviour:
- Reset: asynchronous on rst_n low. State goes to IDLE. out_valid, alu_out, alu_hi, zero_flag, ovf_flag and div_by_zero all reset to 0. An in-flight MUL/DIV is discarded with no output.
- Accept: an operation is accepted when in_valid && in_ready at a clock edge. a, b and alu_control are captured; later input changes are ignored.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This gives back-to-back issue with no bubble.
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT: result 1 or 0, zero-extended
  - 1100 NOR
  - 1010 ADDI: same as ADD
  - 1110 DIV: unsigned
  - 1111 MUL: unsigned, full 2*WIDTH product
  - Any other opcode: alu_out = 0, flags 0
- Single-cycle ops: accept in cycle N gives out_valid in cycle N+1.
- MUL: WIDTH iteration cycles in state MUL, out_valid in cycle N+WIDTH+1.
- DIV, b != 0: WIDTH iteration cycles in state DIV, out_valid in cycle N+WIDTH+1.
- DIV, b == 0: goes straight to DONE, out_valid in cycle N+1. alu_out = all ones, alu_hi = a, div_by_zero = 1.
- States and transitions:
  - IDLE → DONE on accept of a single-cycle op or DIV by 0.
  - IDLE → MUL / DIV on accept of a MUL / nonzero DIV.
  - MUL / DIV → DONE when the iteration counter reaches WIDTH-1.
  - DONE → IDLE on out_ready with no new accept.
  - DONE → DONE / MUL / DIV on out_ready with a new accept.
- Iteration counter: $clog2(WIDTH) bits. Cleared on accept; counts 0..WIDTH-1.
- Output hold: while out_valid && !out_ready, all outputs stay stable and in_ready = 0.
- Flags:
  - zero_flag is computed from the final alu_out value registered in the same cycle, never from a stale value.
  - ovf_flag = operand signs equal and result sign differs (ADD/ADDI); for SUB, A and B signs differ and result sign differs from A.
- Widths: ADD/SUB wrap modulo 2^WIDTH. For MUL, alu_hi:alu_out = a*b exactly.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode localparams: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_ADDI, ALU_DIV, ALU_MUL
  - the state enum: IDLE, MUL, DIV, DONE
- Sub-module alu_muldiv_iter holds the shared WIDTH-cycle shift/accumulate datapath: one 2*WIDTH register pair, mode select mul/div, start/done pulses.
- alu_mc keeps the FSM, handshake, single-cycle ops and flag logic.

Test Plan:
1. All single-cycle ops, WIDTH=32, a=0x0000F0F0, b=0x00FF00FF, out_ready=1 → one result per cycle, no bubble. AND=0x000000F0, OR=0x00FFF0FF, NOR=0xFF000F00. SUB with a=b gives 0, zero_flag=1.
2. ADD a=0x7FFFFFFF, b=1 → alu_out=0x80000000, ovf_flag=1. SLT a=0xFFFFFFFF, b=1: SLT_SIGNED=0 gives 0, SLT_SIGNED=1 gives 1.
3. MUL a=0xFFFFFFFF, b=0xFFFFFFFF → out_valid exactly 33 cycles after accept, alu_hi=0xFFFFFFFE, alu_out=0x00000001. in_ready=0 throughout.
4. DIV a=100, b=7 → alu_out=14, alu_hi=2 after 33 cycles. DIV a=5, b=0 → next cycle alu_out=0xFFFFFFFF, alu_hi=5, div_by_zero=1.
5. Backpressure: out_ready=0 for 5 cycles after a result → outputs stable, in_ready=0. Raising out_ready together with a new in_valid gives a same-cycle handoff.
6. Reset: assert rst_n=0 mid-MUL (cycle 10) → out_valid=0 immediately, asynchronously. After release, in_ready=1 and a following ADD 2+3 returns 5.
